oam_dma: RTL

//  Sprite DMA engine feeding OAM: CPU write to $4014 with page P halts the CPU and

---
 rtl/ppu_pkg.sv | 25 ++
 rtl/oam_dma.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU/CPU-bus definitions: sprite DMA state encoding, the DMA trigger
// register address and the OAM data port address used by register decode,
// the bus arbiter and the sprite DMA engine.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    GET   = 3'd3,
    PUT   = 3'd4
  } dma_state_e;

  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
  localparam int unsigned XFER_LEN      = 256;
  // Index of the final byte of a transfer; the index counter is 8 bits wide.
  localparam logic [7:0]  LAST_IDX      = 8'(XFER_LEN - 1);

  // A CPU write to the sprite DMA register starts a transfer.
  function automatic logic is_dma_trigger(input logic we, input logic [15:0] addr);
    return we && (addr == DMA_REG_ADDR);
  endfunction

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine: a CPU write of page P to $4014 stalls the CPU and copies
// $PP00..$PPFF into the PPU OAM data port, one byte per get/put cycle pair.
// All state advances only on cpu_clk_en; the get/put phase follows a parity
// bit that toggles every CPU cycle, so an alignment cycle is inserted when the
// dummy halt cycle would otherwise leave the first read on an odd cycle.
module oam_dma (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_clk_en,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic        dma_halt,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  input  logic [7:0]  dma_rdata,
  output logic        dma_wr,
  output logic [7:0]  dma_wdata
);
  import ppu_pkg::*;

  dma_state_e r_state;
  dma_state_e w_next_state;
  logic       r_parity;
  logic [7:0] r_idx;
  logic [7:0] r_page;
  logic [7:0] r_data_buf;
  logic       w_trigger;

  assign w_trigger = is_dma_trigger(cpu_we, cpu_addr);

  // State register: advances once per CPU cycle, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (cpu_clk_en) begin
      r_state <= w_next_state;
    end else begin
      r_state <= r_state;
    end
  end

  // Datapath: cycle parity, page latch, byte index and the get->put data buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity   <= 1'b0;
      r_idx      <= 8'h00;
      r_page     <= 8'h00;
      r_data_buf <= 8'h00;
    end else if (cpu_clk_en) begin
      r_parity <= ~r_parity;
      case (r_state)
        IDLE: begin
          // Page is latched only from IDLE, so writes during a run are ignored.
          if (w_trigger) begin
            r_page <= cpu_wdata;
            r_idx  <= 8'h00;
          end else begin
            r_page <= r_page;
            r_idx  <= r_idx;
          end
        end
        GET:     r_data_buf <= dma_rdata;
        // 8-bit wrap keeps the source address inside the page.
        PUT:     r_idx <= r_idx + 8'd1;
        default: r_idx <= r_idx;
      endcase
    end else begin
      r_parity   <= r_parity;
      r_idx      <= r_idx;
      r_page     <= r_page;
      r_data_buf <= r_data_buf;
    end
  end

  // Next-state logic; HALT goes straight to GET only when the next cycle is even.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_trigger) begin
          w_next_state = HALT;
        end else begin
          w_next_state = IDLE;
        end
      end
      HALT: begin
        if (r_parity) begin
          w_next_state = GET;
        end else begin
          w_next_state = ALIGN;
        end
      end
      ALIGN: w_next_state = GET;
      GET:   w_next_state = PUT;
      PUT: begin
        if (r_idx == LAST_IDX) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = GET;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode from registered state only, so outputs are stable per CPU cycle.
  always_comb begin
    dma_halt   = 1'b0;
    dma_active = 1'b0;
    dma_addr   = 16'h0000;
    dma_rd     = 1'b0;
    dma_wr     = 1'b0;
    dma_wdata  = 8'h00;
    case (r_state)
      IDLE: begin
        dma_halt = 1'b0;
      end
      HALT, ALIGN: begin
        dma_halt = 1'b1;
      end
      GET: begin
        dma_halt   = 1'b1;
        dma_active = 1'b1;
        dma_rd     = 1'b1;
        dma_addr   = {r_page, r_idx};
      end
      PUT: begin
        dma_halt   = 1'b1;
        dma_active = 1'b1;
        dma_wr     = 1'b1;
        dma_addr   = OAM_DATA_ADDR;
        dma_wdata  = r_data_buf;
      end
      default: begin
        dma_halt = 1'b0;
      end
    endcase
  end

endmodule
